// File: rtl/output_accumulator_bank.sv
// Per-neuron signed MAC accumulator bank. Products are accumulated round-robin across
// NUM_NEURONS accumulators, then drained through a rescale/ReLU/saturate stage to output RAM.
module output_accumulator_bank #(
    parameter  int NUM_NEURONS = 8,
    parameter  int IN_W        = 16,
    parameter  int ACC_W       = 32,
    parameter  int OUT_W       = 16,
    parameter  int FRAC_BITS   = 8,
    localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  active_z,
    input  logic signed [IN_W-1:0]  active_m,
    input  logic                    next_element,
    input  logic                    last_element,
    input  logic                    relu_en,
    input  logic                    en,
    input  logic                    out_ram_ready,
    output logic [ADDR_W-1:0]       out_ram_address,
    output logic signed [OUT_W-1:0] out_ram_data,
    output logic                    out_ram_write,
    output logic                    busy,
    output logic                    finished,
    output logic                    overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [NUM_NEURONS];
    logic signed [ACC_W-1:0] acc_d [NUM_NEURONS];
    logic [ADDR_W-1:0]       sel_q, sel_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, finished_q;

    logic signed [2*IN_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  rectified;
    logic                     clip_hi, clip_lo;
    logic                     accept;

    always_comb begin
        product     = active_z * active_m;
        product_ext = ACC_W'(product);
        shifted     = acc_q[addr_q] >>> FRAC_BITS;
        rectified   = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
        clip_hi     = rectified > SAT_MAX;
        clip_lo     = rectified < SAT_MIN;
        if (clip_hi) begin
            out_ram_data = SAT_MAX[OUT_W-1:0];
        end else if (clip_lo) begin
            out_ram_data = SAT_MIN[OUT_W-1:0];
        end else begin
            out_ram_data = rectified[OUT_W-1:0];
        end
        out_ram_write = (state_q == DRAIN) && en;
        accept        = out_ram_write && out_ram_ready;
    end

    // start overrides every state, including an abort in the middle of a layer
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        overflow_d = overflow_q;
        if (start) begin
            for (int i = 0; i < NUM_NEURONS; i++) acc_d[i] = '0;
            sel_d      = '0;
            addr_d     = '0;
            overflow_d = 1'b0;
            state_d    = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (next_element) begin
                        acc_d[sel_q] = acc_q[sel_q] + product_ext;
                        sel_d        = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                    end
                    if (last_element) state_d = DRAIN;
                end
                DRAIN: begin
                    if (accept) begin
                        overflow_d = overflow_q | clip_hi | clip_lo;
                        if (addr_q == LAST_IDX) begin
                            addr_d  = '0;
                            state_d = DONE;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_NEURONS; i++) acc_q[i] <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d == ACCUM) || (state_d == DRAIN);
            finished_q <= (state_d == DONE);
        end
    end

    assign out_ram_address = addr_q;
    assign busy            = busy_q;
    assign finished        = finished_q;
    assign overflow        = overflow_q;

endmodule
